// File: rtl/ycbcr_to_rgb_if.sv
// ycbcr_to_rgb_if: AXI4-Stream video beat bundle (tdata/tvalid/tready/tlast/tuser)
interface ycbcr_to_rgb_if #(parameter int DW = 24);
  logic [DW-1:0] tdata;
  logic tvalid;
  logic tready;
  logic tlast;
  logic tuser;
  modport master(output tdata, tvalid, tlast, tuser, input tready);
  modport slave(input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/ycbcr_to_rgb.sv
// ycbcr_to_rgb: 3-stage packed 5:5:5 YCbCr -> 10-bit-per-field RGB, optional YCC2RGB_LSB_REPLICATE_EN fills field LSBs
module ycbcr_to_rgb #(
  parameter int CR_R   = 22,
  parameter int CB_G   = 5,
  parameter int CR_G   = 11,
  parameter int CB_B   = 28,
  parameter int OFFSET = 16
) (
  input  logic clk,
  input  logic rst,
  ycbcr_to_rgb_if.slave  s_axis_video,
  ycbcr_to_rgb_if.master m_axis_video
);
  localparam logic signed [11:0] K_CR_R = 12'(CR_R);
  localparam logic signed [11:0] K_CB_G = 12'(CB_G);
  localparam logic signed [11:0] K_CR_G = 12'(CR_G);
  localparam logic signed [11:0] K_CB_B = 12'(CB_B);
  localparam logic [5:0] K_OFS = 6'(OFFSET);
  logic w_rdy1, w_rdy2, w_rdy3;
  logic r_v1, r_v2, r_v3;
  logic [4:0] r_s1_y;
  logic signed [5:0] r_s1_dcb, r_s1_dcr;
  logic r_s1_last, r_s1_user;
  logic [4:0] r_s2_y;
  logic signed [11:0] r_s2_rt, r_s2_gt, r_s2_bt;
  logic r_s2_last, r_s2_user;
  logic [4:0] r_s3_r, r_s3_g, r_s3_b;
  logic r_s3_last, r_s3_user;
  logic signed [5:0] w_dcb, w_dcr;
  logic signed [11:0] w_dcb_x, w_dcr_x, w_rt, w_gt, w_bt;
  logic signed [11:0] w_y_x, w_r, w_g, w_b;
  logic w_unused;
  function automatic logic [4:0] sat5(input logic signed [11:0] x);
    return x[11] ? 5'd0 : (x > 12'sd31) ? 5'd31 : x[4:0];
  endfunction
  function automatic logic [9:0] fld(input logic [4:0] v);
`ifdef YCC2RGB_LSB_REPLICATE_EN
    return {v, v};
`else
    return {v, 5'b0};
`endif
  endfunction
  // A stage can take a new beat when it is empty or its contents move on this cycle
  always_comb begin
    w_rdy3 = !r_v3 | m_axis_video.tready;
    w_rdy2 = !r_v2 | w_rdy3;
    w_rdy1 = !r_v1 | w_rdy2;
    s_axis_video.tready = w_rdy1 & !rst;
  end
  // Unpack the 5-bit fields and remove the chroma zero level
  always_comb begin
    w_dcb = $signed({1'b0, s_axis_video.tdata[15:11]} - K_OFS);
    w_dcr = $signed({1'b0, s_axis_video.tdata[23:19]} - K_OFS);
    w_unused = &{1'b0, s_axis_video.tdata[18:16], s_axis_video.tdata[10:8], s_axis_video.tdata[2:0]};
  end
  // Chroma contributions in Q4, rounded then floored by the arithmetic shift
  always_comb begin
    w_dcb_x = {{6{r_s1_dcb[5]}}, r_s1_dcb};
    w_dcr_x = {{6{r_s1_dcr[5]}}, r_s1_dcr};
    w_rt = (K_CR_R * w_dcr_x + 12'sd8) >>> 4;
    w_gt = (K_CB_G * w_dcb_x + K_CR_G * w_dcr_x + 12'sd8) >>> 4;
    w_bt = (K_CB_B * w_dcb_x + 12'sd8) >>> 4;
  end
  // Recombine with luma before saturation
  always_comb begin
    w_y_x = $signed({7'b0, r_s2_y});
    w_r = w_y_x + r_s2_rt;
    w_g = w_y_x - r_s2_gt;
    w_b = w_y_x + r_s2_bt;
  end
  // Output word: R, B, G in the top 5 bits of their 10-bit fields
  always_comb begin
    m_axis_video.tdata = {2'b0, fld(r_s3_r), fld(r_s3_b), fld(r_s3_g)};
    m_axis_video.tvalid = r_v3;
    m_axis_video.tlast = r_s3_last;
    m_axis_video.tuser = r_s3_user;
  end
  // Stage 1: field extraction and offset removal
  always_ff @(posedge clk)
    if (rst) begin
      r_v1 <= 1'b0;
      r_s1_y <= '0;
      r_s1_dcb <= '0;
      r_s1_dcr <= '0;
      r_s1_last <= 1'b0;
      r_s1_user <= 1'b0;
    end else if (w_rdy1) begin
      r_v1 <= s_axis_video.tvalid;
      r_s1_y <= s_axis_video.tdata[7:3];
      r_s1_dcb <= w_dcb;
      r_s1_dcr <= w_dcr;
      r_s1_last <= s_axis_video.tlast;
      r_s1_user <= s_axis_video.tuser;
    end
  // Stage 2: coefficient multiplies
  always_ff @(posedge clk)
    if (rst) begin
      r_v2 <= 1'b0;
      r_s2_y <= '0;
      r_s2_rt <= '0;
      r_s2_gt <= '0;
      r_s2_bt <= '0;
      r_s2_last <= 1'b0;
      r_s2_user <= 1'b0;
    end else if (w_rdy2) begin
      r_v2 <= r_v1;
      r_s2_y <= r_s1_y;
      r_s2_rt <= w_rt;
      r_s2_gt <= w_gt;
      r_s2_bt <= w_bt;
      r_s2_last <= r_s1_last;
      r_s2_user <= r_s1_user;
    end
  // Stage 3: add to luma and clamp to 0..31
  always_ff @(posedge clk)
    if (rst) begin
      r_v3 <= 1'b0;
      r_s3_r <= '0;
      r_s3_g <= '0;
      r_s3_b <= '0;
      r_s3_last <= 1'b0;
      r_s3_user <= 1'b0;
    end else if (w_rdy3) begin
      r_v3 <= r_v2;
      r_s3_r <= sat5(w_r);
      r_s3_g <= sat5(w_g);
      r_s3_b <= sat5(w_b);
      r_s3_last <= r_s2_last;
      r_s3_user <= r_s2_user;
    end
endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// tb_ycbcr_to_rgb: table vectors, random traffic against a scoreboard model, backpressure and reset corners
module tb_ycbcr_to_rgb;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  ycbcr_to_rgb_if #(.DW(24)) s();
  ycbcr_to_rgb_if #(.DW(32)) m();
  ycbcr_to_rgb dut(.clk(clk), .rst(rst), .s_axis_video(s), .m_axis_video(m));
  typedef struct {logic [31:0] d; logic l; logic u;} beat_t;
  typedef struct {logic [23:0] din; int r; int g; int b;} vec_t;
  beat_t q[$];
  vec_t tbl[5];
  int occ = 0;
  int n_vec = 0;
  int n_err = 0;
  int n_out = 0;
  bit hold_v = 0;
  logic [33:0] hold;
  bit rand_rdy = 0;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function automatic logic [31:0] pack(int r, int g, int b);
    logic [31:0] d;
    d = (32'(r) << 25) | (32'(b) << 15) | (32'(g) << 5);
`ifdef YCC2RGB_LSB_REPLICATE_EN
    d = d | (32'(r) << 20) | (32'(b) << 10) | 32'(g);
`endif
    return d;
  endfunction
  function automatic int clamp(int x);
    return x < 0 ? 0 : (x > 31 ? 31 : x);
  endfunction
  function automatic logic [31:0] model(logic [23:0] din);
    int y, cb, cr, r, g, b;
    y = int'(din[7:3]);
    cb = int'(din[15:11]) - 16;
    cr = int'(din[23:19]) - 16;
    r = y + int'($floor((1.375 * cr * 16.0 + 8.0) / 16.0));
    g = y - int'($floor((0.3125 * cb * 16.0 + 0.6875 * cr * 16.0 + 8.0) / 16.0));
    b = y + int'($floor((1.75 * cb * 16.0 + 8.0) / 16.0));
    return pack(clamp(r), clamp(g), clamp(b));
  endfunction
  // Scoreboard: handshakes are decided by values settled at the falling edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      occ = 0;
      hold_v = 0;
    end else begin
      chk("s_tready_vs_occupancy", {63'b0, s.tready}, {63'b0, !(occ == 3 && !m.tready)});
      if (hold_v) chk("stall_hold", {29'b0, m.tvalid, m.tlast, m.tuser, m.tdata}, {29'b0, 1'b1, hold});
      hold_v = m.tvalid && !m.tready;
      hold = {m.tlast, m.tuser, m.tdata};
      if (m.tvalid && m.tready) begin
        n_out++;
        occ--;
        if (q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got %h expected none", m.tdata);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("out_beat", {30'b0, m.tlast, m.tuser, m.tdata}, {30'b0, e.l, e.u, e.d});
        end
      end
      if (s.tvalid && s.tready) begin
        q.push_back('{model(s.tdata), s.tlast, s.tuser});
        occ++;
      end
    end
  end
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_rdy) m.tready = 1'($urandom_range(0, 1));
  end
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic send(logic [23:0] d, logic l, logic u);
    bit ok;
    int n;
    n = 0;
    s.tdata = d;
    s.tlast = l;
    s.tuser = u;
    s.tvalid = 1;
    do begin
      @(negedge clk);
      ok = s.tready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: got no tready expected accept");
    end
    s.tvalid = 0;
  endtask
  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      step(1);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    step(2);
  endtask
  initial begin
    int base;
    tbl = '{'{24'h808080, 16, 16, 16}, '{24'hF880F8, 31, 21, 31}, '{24'h000000, 0, 16, 0},
            '{24'h8080F8, 31, 31, 31}, '{24'h00F800, 0, 6, 26}};
    s.tdata = 0;
    s.tvalid = 0;
    s.tlast = 0;
    s.tuser = 0;
    m.tready = 1;
    rst = 1;
    step(3);
    chk("rst_m_tvalid", {63'b0, m.tvalid}, 64'd0);
    chk("rst_s_tready", {63'b0, s.tready}, 64'd0);
    chk("rst_m_data", {30'b0, m.tlast, m.tuser, m.tdata}, 64'd0);
    rst = 0;
    step(1);
    chk("post_rst_m_tvalid", {63'b0, m.tvalid}, 64'd0);
    chk("post_rst_s_tready", {63'b0, s.tready}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      send(tbl[i].din, 1'b0, 1'b0);
      step(1);
      chk("latency_not_early", {63'b0, m.tvalid}, 64'd0);
      step(1);
      chk("latency_valid", {63'b0, m.tvalid}, 64'd1);
      chk("table_data", {32'b0, m.tdata}, {32'b0, pack(tbl[i].r, tbl[i].g, tbl[i].b)});
      step(1);
    end
    base = n_out;
    rand_rdy = 1;
    for (int i = 0; i < 10; i++) send(24'($urandom), i == 7, i == 0);
    rand_rdy = 0;
    m.tready = 1;
    drain();
    chk("burst_count", 64'(n_out - base), 64'd10);
    base = n_out;
    rand_rdy = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) step($urandom_range(1, 3));
      send(24'($urandom), 1'($urandom), 1'($urandom));
    end
    rand_rdy = 0;
    m.tready = 1;
    drain();
    chk("random_count", 64'(n_out - base), 64'd300);
    m.tready = 0;
    step(1);
    for (int i = 0; i < 3; i++) send(24'($urandom), 1'b0, 1'b0);
    chk("full_s_tready", {63'b0, s.tready}, 64'd0);
    chk("full_m_tvalid", {63'b0, m.tvalid}, 64'd1);
    rst = 1;
    #1;
    chk("midrst_s_tready", {63'b0, s.tready}, 64'd0);
    step(1);
    chk("midrst_m_tvalid", {63'b0, m.tvalid}, 64'd0);
    step(1);
    rst = 0;
    step(1);
    chk("after_rst_m_tvalid", {63'b0, m.tvalid}, 64'd0);
    m.tready = 1;
    base = n_out;
    send(24'h808080, 1'b1, 1'b1);
    drain();
    chk("after_rst_count", 64'(n_out - base), 64'd1);
    chk("after_rst_idle", {63'b0, m.tvalid}, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
